ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to the keyboard.

---
 rtl/ps2_host_tx_if.sv | 15 +
 rtl/ps2_host_tx.sv | 161 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_ack;
  logic       tx_error;

  modport master (output tx_valid, tx_data,
                  input  tx_ready, busy, tx_done, tx_ack, tx_error);
  modport slave  (input  tx_valid, tx_data,
                  output tx_ready, busy, tx_done, tx_ack, tx_error);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send and
// clocks one command byte out on the device's clock, driving the pins open-drain.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned BIT_TIMEOUT    = 100000
) (
  input  logic         clk,
  input  logic         rst_n,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_drive_low,
  output logic         ps2_data_drive_low
);
  localparam int unsigned MAX_A = (INHIBIT_CYCLES > BIT_TIMEOUT) ? INHIBIT_CYCLES : BIT_TIMEOUT;
  localparam int unsigned MAX_P = (START_TIMEOUT > MAX_A) ? START_TIMEOUT : MAX_A;
  localparam int unsigned CTR_W = $clog2(MAX_P) + 1;
  localparam logic [CTR_W-1:0] INH_LAST   = CTR_W'(INHIBIT_CYCLES - 1);
  localparam logic [CTR_W-1:0] START_LAST = CTR_W'(START_TIMEOUT - 1);
  localparam logic [CTR_W-1:0] BIT_LAST   = CTR_W'(BIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_ERROR
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_clk_meta, r_clk_sync, r_clk_prev, r_data_meta, r_data_sync;
  logic [9:0]       r_shift;
  logic [3:0]       r_bitcnt;
  logic [CTR_W-1:0] r_ctr;
  logic             r_ack;
  logic             r_clk_low, r_data_low, r_tx_ready, r_busy, r_tx_done, r_tx_ack, r_tx_error;
  logic             w_clk_low_nxt, w_data_low_nxt, w_done_nxt, w_error_nxt;
  logic             w_fall, w_accept, w_line_phase;
  logic [CTR_W-1:0] w_send_limit;

  // Pin synchronizers; the extra clock flop provides the falling-edge history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_clk_prev  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
    end else begin
      r_clk_meta  <= ps2_clk_i;
      r_clk_sync  <= r_clk_meta;
      r_clk_prev  <= r_clk_sync;
      r_data_meta <= ps2_data_i;
      r_data_sync <= r_data_meta;
    end
  end

  assign w_fall       = r_clk_prev & ~r_clk_sync;
  assign w_accept     = (r_state == S_IDLE) & r_tx_ready & bus.tx_valid;
  assign w_send_limit = (r_bitcnt == 4'd0) ? START_LAST : BIT_LAST;
  assign w_line_phase = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_state_nxt = S_INHIBIT;
      S_INHIBIT:   if (r_ctr == INH_LAST) w_state_nxt = S_REQ;
      S_REQ:       w_state_nxt = S_SEND;
      S_SEND: begin
        if (w_fall) begin
          if (r_bitcnt == 4'd9) w_state_nxt = S_ACK;
        end else if (r_ctr == w_send_limit) begin
          w_state_nxt = S_ERROR;
        end
      end
      S_ACK: begin
        if (w_fall)                 w_state_nxt = S_WAIT_IDLE;
        else if (r_ctr == BIT_LAST) w_state_nxt = S_ERROR;
      end
      S_WAIT_IDLE: begin
        if (r_clk_sync && r_data_sync) w_state_nxt = S_IDLE;
        else if (r_ctr == BIT_LAST)    w_state_nxt = S_ERROR;
      end
      S_ERROR:     w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; the start bit is held from REQ into SEND
  always_comb begin
    w_clk_low_nxt  = (w_state_nxt == S_INHIBIT) || (w_state_nxt == S_REQ);
    w_data_low_nxt = 1'b0;
    if (w_state_nxt == S_REQ) begin
      w_data_low_nxt = 1'b1;
    end else if (w_state_nxt == S_SEND) begin
      if (r_state != S_SEND) w_data_low_nxt = 1'b1;
      else if (w_fall)       w_data_low_nxt = ~r_shift[0];
      else                   w_data_low_nxt = r_data_low;
    end
    w_done_nxt  = (r_state == S_WAIT_IDLE) && (w_state_nxt == S_IDLE);
    w_error_nxt = (w_state_nxt == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_ctr    <= '0;
      r_ack    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift  <= {1'b1, ~^bus.tx_data, bus.tx_data};
        r_bitcnt <= '0;
        r_ack    <= 1'b0;
      end else if ((r_state == S_SEND) && w_fall) begin
        r_shift  <= {1'b0, r_shift[9:1]};
        r_bitcnt <= r_bitcnt + 4'd1;
      end else if ((r_state == S_ACK) && w_fall) begin
        r_ack    <= ~r_data_sync;
      end

      // Edges while the host owns the clock are its own and must not stretch INHIBIT
      if ((r_state == S_IDLE) || (w_state_nxt != r_state))
        r_ctr <= '0;
      else if (w_fall && w_line_phase)
        r_ctr <= '0;
      else
        r_ctr <= r_ctr + CTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clk_low  <= 1'b0;
      r_data_low <= 1'b0;
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_ack   <= 1'b0;
      r_tx_error <= 1'b0;
    end else begin
      r_clk_low  <= w_clk_low_nxt;
      r_data_low <= w_data_low_nxt;
      r_tx_ready <= (w_state_nxt == S_IDLE);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_tx_done  <= w_done_nxt;
      r_tx_ack   <= w_done_nxt & r_ack;
      r_tx_error <= w_error_nxt;
    end
  end

  assign ps2_clk_drive_low  = r_clk_low;
  assign ps2_data_drive_low = r_data_low;
  assign bus.tx_ready       = r_tx_ready;
  assign bus.busy           = r_busy;
  assign bus.tx_done        = r_tx_done;
  assign bus.tx_ack         = r_tx_ack;
  assign bus.tx_error       = r_tx_error;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain PS/2 device model plus a scoreboard of
// expected frame outcomes checked whenever the DUT pulses done or error.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int unsigned INH  = 20;
  localparam int unsigned STO  = 300;
  localparam int unsigned BTO  = 150;
  localparam int unsigned HALF = 20;

  typedef struct packed {
    logic        is_err;
    logic        ack;
    logic [10:0] frame;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  ps2_host_tx_if bus();
  logic ps2_clk_drive_low, ps2_data_drive_low;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic clk_line, data_line;
  assign clk_line  = ~(ps2_clk_drive_low | dev_clk_low);
  assign data_line = ~(ps2_data_drive_low | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(STO), .BIT_TIMEOUT(BTO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ps2_clk_i(clk_line), .ps2_data_i(data_line),
    .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;
  int cyc = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Device model: 0 = normal with ACK, 1 = no ACK, 2 = never clocks, 3 = stop after dev_stop edges
  int dev_mode = 0;
  int dev_stop = 4;
  int dev_edges = 0;
  int dev_fall_cyc = 0;
  logic [10:0] dev_frame = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (ps2_clk_drive_low) begin
        while (ps2_clk_drive_low || !ps2_data_drive_low) @(negedge clk);
        dev_edges = 0;
        dev_frame = {data_line, 10'b0};
        if (dev_mode != 2) begin
          for (int k = 0; k < 11; k++) begin
            if (!(dev_mode == 3 && k >= dev_stop)) begin
              if (k == 10 && dev_mode == 0) dev_data_low = 1'b1;
              repeat (HALF) @(negedge clk);
              dev_clk_low = 1'b1;
              dev_edges++;
              dev_fall_cyc = cyc;
              repeat (HALF) @(negedge clk);
              if (k < 10) dev_frame = {data_line, dev_frame[10:1]};
              dev_clk_low = 1'b0;
            end
          end
        end
        dev_data_low = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.tx_done || bus.tx_error) begin
        n_pulse++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pulse: done=%0b error=%0b with nothing outstanding", bus.tx_done, bus.tx_error);
        end else begin
          e = sb.pop_front();
          chk("outcome_is_error", 32'(bus.tx_error), 32'(e.is_err));
          if (!e.is_err) begin
            chk("tx_ack", 32'(bus.tx_ack), 32'(e.ack));
            chk("line_frame", 32'(dev_frame), 32'(e.frame));
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit expect_pulse, input exp_t e);
    if (expect_pulse) sb.push_back(e);
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
  endtask

  task automatic wait_pulse(input string nm, input int bound);
    int n = 0;
    while (!(bus.tx_done || bus.tx_error) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no done/error within %0d cycles", nm, bound);
    end
  endtask

  task automatic after_done(input string nm);
    @(negedge clk);
    chk({nm, "_busy_after"}, 32'(bus.busy), 32'd0);
    chk({nm, "_done_single"}, 32'(bus.tx_done), 32'd0);
  endtask

  initial begin
    int n, m, p0, extra;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_clk_drive", 32'(ps2_clk_drive_low), 32'd0);
    chk("rst_data_drive", 32'(ps2_data_drive_low), 32'd0);
    chk("rst_ready", 32'(bus.tx_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.tx_done), 32'd0);
    chk("rst_error", 32'(bus.tx_error), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xED with ACK; inhibit length measured before the start bit appears
    dev_mode = 0;
    send(8'hED, 1'b1, '{is_err: 1'b0, ack: 1'b1, frame: 11'b11111011010});
    chk("inhibit_busy", 32'(bus.busy), 32'd1);
    n = 0;
    while (ps2_clk_drive_low && !ps2_data_drive_low && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("inhibit_cycles", 32'(n), 32'(INH));
    chk("req_clk_low", 32'(ps2_clk_drive_low), 32'd1);
    wait_pulse("ed_frame", 2000);
    after_done("ed");

    // 0xF4: parity bit 0
    send(8'hF4, 1'b1, '{is_err: 1'b0, ack: 1'b1, frame: 11'b10111101000});
    wait_pulse("f4_frame", 2000);
    after_done("f4");

    // Device never clocks
    dev_mode = 2;
    send(8'h55, 1'b1, '{is_err: 1'b1, ack: 1'b0, frame: 11'b0});
    n = 0;
    while (ps2_clk_drive_low && n < 200) begin
      n++;
      @(negedge clk);
    end
    m = 0;
    while (!bus.tx_error && m < int'(STO) + 50) begin
      m++;
      @(negedge clk);
    end
    chk("start_timeout_cycles", 32'(m), 32'(STO));
    chk("err_clk_drive", 32'(ps2_clk_drive_low), 32'd0);
    chk("err_data_drive", 32'(ps2_data_drive_low), 32'd0);
    @(negedge clk);
    chk("err_ready_after", 32'(bus.tx_ready), 32'd1);
    chk("err_single", 32'(bus.tx_error), 32'd0);

    // No ACK from the device
    dev_mode = 1;
    send(8'h00, 1'b1, '{is_err: 1'b0, ack: 1'b0, frame: 11'b11000000000});
    wait_pulse("nack_frame", 2000);
    after_done("nack");

    // Device stops after 4 edges
    dev_mode = 3;
    dev_stop = 4;
    send(8'hA5, 1'b1, '{is_err: 1'b1, ack: 1'b0, frame: 11'b0});
    wait_pulse("bit_timeout", 2000);
    chk("bit_timeout_edges", 32'(dev_edges), 32'd4);
    chk("bit_timeout_cycles", 32'(cyc - dev_fall_cyc), 32'(BTO + 3));
    repeat (2) @(negedge clk);

    // Reset during bit 5: lines released at once, no completion pulse
    dev_stop = 5;
    send(8'h3C, 1'b0, '0);
    n = 0;
    while (dev_edges < 5 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("reset_reached_bit5", 32'(dev_edges), 32'd5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_clk_drive", 32'(ps2_clk_drive_low), 32'd0);
    chk("midrst_data_drive", 32'(ps2_data_drive_low), 32'd0);
    chk("midrst_ready", 32'(bus.tx_ready), 32'd1);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    p0 = n_pulse;
    repeat (BTO + 60) @(negedge clk);
    chk("midrst_no_pulse", 32'(n_pulse), 32'(p0));

    // A second request while busy must be dropped
    dev_mode = 0;
    send(8'h12, 1'b1, '{is_err: 1'b0, ack: 1'b1, frame: 11'b11000100100});
    repeat (5) @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    repeat (3) @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    wait_pulse("busy_drop_frame", 2000);
    after_done("busy_drop");
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ps2_clk_drive_low || bus.busy) extra++;
    end
    chk("no_second_frame", 32'(extra), 32'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
